// File: rtl/bch_gf_pkg.sv
// -----------------------------------------------------------------------------
// bch_gf_pkg
// Shared definitions for the binary BCH decoder over GF(2^13).
//   M      : field degree (element width in bits)
//   DEF_T  : default correction capability
//   POLY   : field generator polynomial x^13 + x^4 + x^3 + x + 1
//   elem_t : polynomial-basis field element
//   state_t: key-equation solver FSM states
//   gf_mul : combinational polynomial-basis multiply, reduced by POLY
// -----------------------------------------------------------------------------
package bch_gf_pkg;

    localparam int M     = 13;
    localparam int DEF_T = 8;

    localparam logic [M:0] POLY = 14'h201B;

    typedef logic [M-1:0] elem_t;

    localparam elem_t ONE = elem_t'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISC,
        ST_INV,
        ST_UPD,
        ST_DONE
    } state_t;

    // Shift-and-add multiply: walk the bits of b, keeping a*x^n reduced.
    function automatic elem_t gf_mul(elem_t a, elem_t b);
        elem_t acc;
        elem_t sh;
        acc = '0;
        sh  = a;
        for (int n = 0; n < M; n++) begin
            if (b[n]) acc ^= sh;
            sh = sh[M-1] ? ((sh << 1) ^ POLY[M-1:0]) : (sh << 1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/bch_bm_solver_if.sv
// -----------------------------------------------------------------------------
// bch_bm_solver_if
// Request/result bundle between the syndrome stage, the key-equation solver
// and the Chien search.
//   start : request to start a solve
//   syn   : 2T syndromes, S_j in bits [M*j-1 : M*(j-1)]
//   busy  : solver active
//   done  : one-cycle pulse, results valid from this cycle on
//   sigma : T+1 locator coefficients, sigma_i in bits [M*i+M-1 : M*i]
//   deg   : final locator degree L
//   fail  : L > T (uncorrectable)
// master = requester side, slave = solver side.
// -----------------------------------------------------------------------------
interface bch_bm_solver_if
    import bch_gf_pkg::*;
#(
    parameter int T = DEF_T
);

    logic                   start;
    logic [M*2*T-1:0]       syn;
    logic                   busy;
    logic                   done;
    logic [M*(T+1)-1:0]     sigma;
    logic [4:0]             deg;
    logic                   fail;

    modport master (
        output start, syn,
        input  busy, done, sigma, deg, fail
    );

    modport slave (
        input  start, syn,
        output busy, done, sigma, deg, fail
    );

endinterface

// File: rtl/parallel_inverse.sv
// -----------------------------------------------------------------------------
// parallel_inverse
// Combinational GF(2^13) inverse via Fermat: a^-1 = a^(2^13 - 2).
// 2^13 - 2 = 2 + 4 + ... + 4096, so the result is the product of the
// twelve successive squares of a. An input of 0 yields 0.
//   a : operand
//   y : multiplicative inverse of a
// -----------------------------------------------------------------------------
module parallel_inverse
    import bch_gf_pkg::*;
(
    input  elem_t a,
    output elem_t y
);

    function automatic elem_t inv_pow(elem_t x);
        elem_t sq;
        elem_t acc;
        sq  = x;
        acc = ONE;
        for (int n = 1; n < M; n++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    assign y = inv_pow(a);

endmodule

// File: rtl/pb_mult_new.sv
// -----------------------------------------------------------------------------
// pb_mult_new
// Combinational GF(2^13) polynomial-basis multiplier.
//   a, b : operands
//   p    : a * b mod POLY
// -----------------------------------------------------------------------------
module pb_mult_new
    import bch_gf_pkg::*;
(
    input  elem_t a,
    input  elem_t b,
    output elem_t p
);

    assign p = gf_mul(a, b);

endmodule

// File: rtl/bch_bm_solver.sv
// -----------------------------------------------------------------------------
// bch_bm_solver
// Simplified binary Berlekamp-Massey key-equation solver. Each of the T
// iterations computes the discrepancy serially (T+1 cycles), registers its
// inverse (1 cycle) and updates sigma/B serially in descending index order
// (T+1 cycles), so one solve takes T*(2T+3)+1 cycles from accept to done.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of bch_bm_solver_if (start/syn in, results out)
// -----------------------------------------------------------------------------
module bch_bm_solver
    import bch_gf_pkg::*;
#(
    parameter int T = DEF_T
) (
    input  logic           clk,
    input  logic           rst_n,
    bch_bm_solver_if.slave bus
);

    localparam int CW = $clog2(2 * T + 2);

    state_t          state;
    elem_t           syn_q   [2*T];
    elem_t           sig     [T+1];
    elem_t           bb      [T+1];
    elem_t           sig_out [T+1];
    elem_t           d;
    elem_t           d_inv;
    logic            c;
    logic [CW-1:0]   i;
    logic [CW-1:0]   k;
    logic [4:0]      l;
    logic            busy_q;
    logic            done_q;
    logic            fail_q;
    logic [4:0]      deg_q;

    elem_t           s_sel;
    elem_t           sig_i;
    elem_t           sig_m2;
    elem_t           b_i;
    elem_t           b_m2;
    elem_t           mac_p;
    elem_t           db_p;
    elem_t           sdi_p;
    elem_t           inv_y;
    logic [4:0]      l_next;

    // Operand selection by the shared coefficient counter i.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        s_sel  = '0;
        sig_i  = '0;
        sig_m2 = '0;
        b_i    = '0;
        b_m2   = '0;
        // S_{2k+1-i}; indices below 1 leave the term at zero.
        for (int j = 1; j <= 2 * T; j++) begin
            if (2 * int'(k) + 1 - int'(i) == j) s_sel = syn_q[j-1];
        end
        // sigma_{i-2} / B_{i-2}; negative indices read as zero.
        for (int n = 0; n <= T; n++) begin
            if (int'(i) == n) begin
                sig_i = sig[n];
                b_i   = bb[n];
            end
            if (int'(i) == n + 2) begin
                sig_m2 = sig[n];
                b_m2   = bb[n];
            end
        end
        l_next = c ? 5'(2 * int'(k) + 1 - int'(l)) : l;
    end

    pb_mult_new u_mac (.a(sig_i),  .b(s_sel), .p(mac_p));
    pb_mult_new u_db  (.a(d),      .b(b_i),   .p(db_p));
    pb_mult_new u_sdi (.a(sig_m2), .b(d_inv), .p(sdi_p));

    parallel_inverse u_inv (.a(d), .y(inv_y));

    // Coefficient and syndrome storage.
    // NOTE: these arrays carry no reset; every solve loads them at accept before any read.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.start) begin
            for (int j = 0; j < 2 * T; j++) syn_q[j] <= bus.syn[M*j +: M];
            for (int n = 0; n <= T; n++) begin
                sig[n] <= (n == 0) ? ONE : '0;
                bb[n]  <= (n == 1) ? ONE : '0;
            end
        end else if (state == ST_UPD) begin
            // Descending i keeps sigma_{i-2}/B_{i-2} at their old values here.
            for (int n = 0; n <= T; n++) begin
                if (int'(i) == n) begin
                    sig[n] <= sig[n] ^ db_p;
                    bb[n]  <= c ? sdi_p : b_m2;
                end
            end
        end
    end

    // Control FSM with registered outputs.
    // NOTE: state is updated with non-blocking assignments so every read in this edge sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
            deg_q  <= '0;
            for (int n = 0; n <= T; n++) sig_out[n] <= '0;
            i      <= '0;
            k      <= '0;
            l      <= '0;
            d      <= '0;
            d_inv  <= '0;
            c      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        i      <= '0;
                        k      <= '0;
                        l      <= '0;
                        d      <= '0;
                        state  <= ST_DISC;
                    end
                end
                ST_DISC: begin
                    d <= d ^ mac_p;
                    if (int'(i) == T) state <= ST_INV;
                    else              i     <= i + 1'b1;
                end
                ST_INV: begin
                    d_inv <= inv_y;
                    c     <= (d != '0) && (int'(l) <= int'(k));
                    i     <= CW'(T);
                    state <= ST_UPD;
                end
                ST_UPD: begin
                    if (i == '0) begin
                        l <= l_next;
                        k <= k + 1'b1;
                        if (int'(k) + 1 == T) begin
                            // Final step also writes sigma_0, so fold it into the output copy.
                            for (int n = 0; n <= T; n++)
                                sig_out[n] <= (n == 0) ? (sig[0] ^ db_p) : sig[n];
                            deg_q  <= l_next;
                            fail_q <= int'(l_next) > T;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            d     <= '0;
                            state <= ST_DISC;
                        end
                    end else begin
                        i <= i - 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.deg  = deg_q;
    assign bus.fail = fail_q;

    for (genvar n = 0; n <= T; n++) begin : g_sigma
        assign bus.sigma[M*n +: M] = sig_out[n];
    end

endmodule

// File: tb/tb_bch_bm_solver.sv
// -----------------------------------------------------------------------------
// tb_bch_bm_solver
// Self-checking bench for bch_bm_solver (T = 8). Syndromes come from known
// error positions (or are random); results are compared with a polynomial-
// level Berlekamp-Massey model built on log/antilog tables, and locators for
// correctable patterns are also checked by evaluating sigma at the inverse
// error locators.
// -----------------------------------------------------------------------------
module tb_bch_bm_solver;
    import bch_gf_pkg::*;

    localparam int T   = 8;
    localparam int N   = 8191;
    localparam int LAT = T * (2 * T + 3) + 1;

    typedef elem_t poly_t [T+1];
    typedef elem_t syn_t  [2*T];

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   alog [N];
    int   lg   [N+1];

    bch_bm_solver_if #(.T(T)) bus ();
    bch_bm_solver #(.T(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic build_tables();
        int x;
        x = 1;
        for (int e = 0; e < N; e++) begin
            alog[e] = x;
            lg[x]   = e;
            x = x << 1;
            if ((x & 32'h2000) != 0) x ^= 32'h201B;
        end
        lg[0] = 0;
    endtask

    function automatic elem_t gm(elem_t a, elem_t b);
        if (a == '0 || b == '0) return '0;
        return elem_t'(alog[(lg[a] + lg[b]) % N]);
    endfunction

    function automatic elem_t gi(elem_t a);
        if (a == '0) return '0;
        return elem_t'(alog[(N - lg[a]) % N]);
    endfunction

    function automatic elem_t apow(int e);
        return elem_t'(alog[((e % N) + N) % N]);
    endfunction

    function automatic elem_t peval(poly_t p, int e);
        elem_t acc;
        acc = '0;
        for (int n = 0; n <= T; n++) acc ^= gm(p[n], apow(e * n));
        return acc;
    endfunction

    task automatic make_syn(input int pos[$], output syn_t s);
        for (int j = 1; j <= 2 * T; j++) begin
            s[j-1] = '0;
            foreach (pos[q]) s[j-1] ^= apow(pos[q] * j);
        end
    endtask

    task automatic rand_pos(input int cnt, output int pos[$]);
        int p;
        bit dup;
        pos = {};
        while (pos.size() < cnt) begin
            p   = $urandom_range(0, N - 1);
            dup = 1'b0;
            foreach (pos[q]) if (pos[q] == p) dup = 1'b1;
            if (!dup) pos.push_back(p);
        end
    endtask

    // Whole-polynomial binary BM: sigma' = sigma + d*B,
    // B' = x^2 * (c ? sigma/d : B), everything truncated to degree T.
    task automatic model_bm(input syn_t s, output poly_t sg, output int lq);
        poly_t b;
        poly_t nsg;
        poly_t nb;
        elem_t d;
        elem_t dinv;
        bit    c;
        lq = 0;
        for (int n = 0; n <= T; n++) begin
            sg[n] = '0;
            b[n]  = '0;
        end
        sg[0] = 1;
        b[1]  = 1;
        for (int k = 0; k < T; k++) begin
            d = '0;
            for (int n = 0; n <= T; n++)
                if (2 * k + 1 - n >= 1) d ^= gm(sg[n], s[2*k-n]);
            c    = (d != '0) && (lq <= k);
            dinv = gi(d);
            for (int n = 0; n <= T; n++) begin
                nsg[n] = sg[n] ^ gm(d, b[n]);
                nb[n]  = (n < 2) ? '0 : (c ? gm(sg[n-2], dinv) : b[n-2]);
            end
            sg = nsg;
            b  = nb;
            if (c) lq = 2 * k + 1 - lq;
        end
    endtask

    // One solve: model compare, latency, busy/done framing and output hold.
    task automatic solve_and_check(input string tag, input syn_t s, input int restart_at,
                                   output poly_t got, output int got_deg);
        poly_t exp_sg;
        int    exp_l;
        int    n;
        model_bm(s, exp_sg, exp_l);
        @(negedge clk);
        for (int j = 0; j < 2 * T; j++) bus.syn[M*j +: M] = s[j];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        // Syndromes must have been latched; disturb the bus on purpose.
        for (int j = 0; j < 2 * T; j++) bus.syn[M*j +: M] = elem_t'($urandom);
        n = 1;
        check({tag, "_busy_on"}, bus.busy, 1);
        while (!bus.done && n < 4 * LAT) begin
            bus.start = (n == restart_at);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, n, LAT);
        check({tag, "_busy_done"}, bus.busy, 1);
        for (int q = 0; q <= T; q++) begin
            got[q] = bus.sigma[M*q +: M];
            check($sformatf("%s_sigma%0d", tag, q), got[q], exp_sg[q]);
        end
        got_deg = int'(bus.deg);
        check({tag, "_deg"}, bus.deg, exp_l);
        check({tag, "_fail"}, bus.fail, (exp_l > T) ? 1 : 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_busy_off"}, bus.busy, 0);
        check({tag, "_deg_hold"}, bus.deg, exp_l);
        check({tag, "_sigma0_hold"}, bus.sigma[M-1:0], exp_sg[0]);
    endtask

    task automatic check_roots(input string tag, input poly_t sg, input int pos[$]);
        foreach (pos[q]) check(tag, peval(sg, -pos[q]), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        syn_t  s;
        poly_t got;
        int    gd;
        int    pos[$];
        int    roots;
        int    pulses;
        int    n;

        build_tables();
        bus.start = 1'b0;
        bus.syn   = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_deg",   bus.deg, 0);
        check("rst_fail",  bus.fail, 0);
        check("rst_sigma", |bus.sigma, 0);
        rst_n = 1'b1;

        // All-zero syndromes: sigma = 1.
        pos = {};
        make_syn(pos, s);
        solve_and_check("zero", s, 0, got, gd);
        check("zero_s0", got[0], 1);
        for (int q = 1; q <= T; q++) check("zero_sq", got[q], 0);
        check("zero_deg_c", gd, 0);

        // Single error at position 5.
        pos = {5};
        make_syn(pos, s);
        solve_and_check("one", s, 0, got, gd);
        check("one_s0", got[0], 1);
        check("one_s1", got[1], apow(5));
        for (int q = 2; q <= T; q++) check("one_sq", got[q], 0);
        check("one_deg_c", gd, 1);

        // Two errors at 3 and 100: (1 + a^3 x)(1 + a^100 x).
        pos = {3, 100};
        make_syn(pos, s);
        solve_and_check("two", s, 0, got, gd);
        check("two_s1", got[1], apow(3) ^ apow(100));
        check("two_s2", got[2], apow(103));
        check("two_deg_c", gd, 2);

        // Eight random errors: full capability.
        for (int r = 0; r < 3; r++) begin
            rand_pos(8, pos);
            make_syn(pos, s);
            solve_and_check("eight", s, 0, got, gd);
            check("eight_deg_c", gd, 8);
            check_roots("eight_root", got, pos);
        end

        // Nine errors: cannot locate all of them.
        for (int r = 0; r < 2; r++) begin
            rand_pos(9, pos);
            make_syn(pos, s);
            solve_and_check("nine", s, 0, got, gd);
            roots = 0;
            foreach (pos[q]) if (peval(got, -pos[q]) == '0) roots++;
            check("nine_roots_lt9", (roots < 9) ? 1 : 0, 1);
        end

        // Arbitrary syndrome vectors exercise every branch of the update.
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 2 * T; j++) s[j] = elem_t'($urandom);
            solve_and_check("rnd", s, 0, got, gd);
        end

        // start re-asserted mid-solve is ignored.
        rand_pos(3, pos);
        make_syn(pos, s);
        solve_and_check("restart", s, 10, got, gd);
        check_roots("restart_root", got, pos);

        // Reset at C+50 aborts with no done pulse.
        rand_pos(5, pos);
        make_syn(pos, s);
        @(negedge clk);
        for (int j = 0; j < 2 * T; j++) bus.syn[M*j +: M] = s[j];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        pulses = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (bus.done) pulses++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy",  bus.busy, 0);
        check("abort_done",  bus.done, 0);
        check("abort_deg",   bus.deg, 0);
        check("abort_fail",  bus.fail, 0);
        check("abort_sigma", |bus.sigma, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * LAT; c++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_idle", bus.busy, 0);

        // A fresh solve after the abort works normally.
        rand_pos(4, pos);
        make_syn(pos, s);
        solve_and_check("after", s, 0, got, gd);
        check("after_deg_c", gd, 4);
        check_roots("after_root", got, pos);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
